// File: rtl/l1_line_cache_if.sv
// Bus bundle for l1_line_cache: the CPU word port and the memory line port.
// The slave modport is the cache's view; the master modport is the
// environment's view (the CPU requester plus the backing memory).
interface l1_line_cache_if;
    // CPU word port
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    // Memory line port
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_rdata;
    logic [255:0] pmem_wdata;
    logic         pmem_resp;

    modport slave (
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        output mem_rdata, mem_resp,
        output pmem_address, pmem_read, pmem_write, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        input  mem_rdata, mem_resp,
        input  pmem_address, pmem_read, pmem_write, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/l1_line_cache.sv
// l1_line_cache: direct-mapped, write-back, write-allocate line cache between
// the multicycle RV32I core and physical memory. 32-byte lines, 2**S_INDEX sets,
// all storage in flops so hits respond in the request cycle.
// Optional performance counters are enabled with `define L1_CACHE_PERF_CNT_EN.
module l1_line_cache #(
    parameter int S_INDEX = 3
) (
    input logic            clk,
    input logic            rst,
    l1_line_cache_if.slave bus
`ifdef L1_CACHE_PERF_CNT_EN
    ,
    output logic [31:0]    perf_hits,
    output logic [31:0]    perf_misses,
    output logic [31:0]    perf_writebacks
`endif
);
    localparam int SETS  = 1 << S_INDEX;
    localparam int TAG_W = 27 - S_INDEX;

    typedef enum logic [1:0] {CHECK, WRITEBACK, FILL} state_t;

    state_t              state_q;
    logic [SETS-1:0]     valid_q;
    logic [SETS-1:0]     dirty_q;
    logic [TAG_W-1:0]    tag_q  [SETS];
    logic [255:0]        data_q [SETS];

    // Address decode; the live CPU address is used for the whole miss.
    logic [S_INDEX-1:0]  idx;
    logic [TAG_W-1:0]    tag;
    logic [2:0]          off;
    assign idx = bus.mem_address[5 +: S_INDEX];
    assign tag = bus.mem_address[31 -: TAG_W];
    assign off = bus.mem_address[4:2];

    logic req, hit, hit_resp, victim_dirty, hit_wr_en, fill_en;
    assign req          = bus.mem_read | bus.mem_write;
    assign hit          = valid_q[idx] && (tag_q[idx] == tag);
    assign hit_resp     = (state_q == CHECK) && req && hit;
    assign victim_dirty = valid_q[idx] && dirty_q[idx];
    // A write wins when both strobes are high; reset suppresses array updates.
    assign hit_wr_en    = hit_resp && bus.mem_write && !rst;
    assign fill_en      = (state_q == FILL) && bus.pmem_resp && !rst;

    logic [255:0] line_cur;
    logic [255:0] line_d;
    logic [31:0]  word_cur;
    logic [31:0]  word_d;
    assign line_cur = data_q[idx];
    assign word_cur = line_cur[{off, 5'b0} +: 32];

    // Byte-lane merge of the CPU write data into the addressed word of the line.
    always_comb begin
        word_d = word_cur;
        for (int b = 0; b < 4; b++) begin
            if (bus.mem_byte_enable[b]) begin
                word_d[b*8 +: 8] = bus.mem_wdata[b*8 +: 8];
            end
        end
        line_d = line_cur;
        line_d[{off, 5'b0} +: 32] = word_d;
    end

    // Outputs decoded from state; the memory strobes are mutually exclusive.
    assign bus.mem_resp     = hit_resp;
    assign bus.mem_rdata    = word_cur;
    assign bus.pmem_read    = (state_q == FILL);
    assign bus.pmem_write   = (state_q == WRITEBACK);
    assign bus.pmem_wdata   = line_cur;
    assign bus.pmem_address = (state_q == WRITEBACK) ? {tag_q[idx], idx, 5'b0}
                                                     : {bus.mem_address[31:5], 5'b0};

    // Line data and tag storage: refill on fill completion, merge on write hit.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_q[idx] <= bus.pmem_rdata;
            tag_q[idx]  <= tag;
        end else if (hit_wr_en) begin
            data_q[idx] <= line_d;
        end
    end

    // Controller FSM with valid/dirty bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CHECK;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            case (state_q)
                CHECK: begin
                    if (hit_resp) begin
                        if (bus.mem_write) begin
                            dirty_q[idx] <= 1'b1;
                        end
                    end else if (req) begin
                        state_q <= victim_dirty ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    if (bus.pmem_resp) begin
                        dirty_q[idx] <= 1'b0;
                        state_q      <= FILL;
                    end
                end
                FILL: begin
                    if (bus.pmem_resp) begin
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                        state_q      <= CHECK;
                    end
                end
                default: state_q <= CHECK;
            endcase
        end
    end

`ifdef L1_CACHE_PERF_CNT_EN
    logic [31:0] hits_q, misses_q, wbs_q;
    logic        miss_pend_q;

    // Event counters; the response that ends a miss is not counted as a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            hits_q      <= '0;
            misses_q    <= '0;
            wbs_q       <= '0;
            miss_pend_q <= 1'b0;
        end else begin
            if (hit_resp) begin
                if (!miss_pend_q) begin
                    hits_q <= hits_q + 32'd1;
                end
                miss_pend_q <= 1'b0;
            end else if ((state_q == CHECK) && req) begin
                misses_q    <= misses_q + 32'd1;
                miss_pend_q <= 1'b1;
            end
            if ((state_q == WRITEBACK) && bus.pmem_resp) begin
                wbs_q <= wbs_q + 32'd1;
            end
        end
    end

    assign perf_hits       = hits_q;
    assign perf_misses     = misses_q;
    assign perf_writebacks = wbs_q;
`endif
endmodule

// File: doc/l1_line_cache.md
Name: l1_line_cache

Overview:
- Direct-mapped, write-back, write-allocate cache between the multicycle RV32I control/datapath and physical memory.
- CPU side uses the core's existing word interface: mem_read/mem_write/mem_byte_enable/mem_resp, held until response.
- Memory side moves whole 256-bit (32-byte) lines with a single-beat read/write handshake.
- Removes memory latency from the fetch and load/store states on hits.

Parameters:
- S_INDEX, 3, index bits; 2**S_INDEX sets (default 8).
- Fixed, not parameters: offset = 5 bits (32-byte line); tag = 27 - S_INDEX bits.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- mem_address  in  32  CPU byte address; bits [1:0] ignored
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_byte_enable  in  4  byte lanes of mem_wdata to write
- mem_wdata  in  32  CPU write data
- mem_rdata  out  32  word at mem_address[4:2] of the hit line
- mem_resp  out  1  one-cycle completion pulse
- pmem_address  out  32  line address, bits [4:0] = 0
- pmem_read  out  1  line fill request, held until pmem_resp
- pmem_write  out  1  line writeback request, held until pmem_resp
- pmem_rdata  in  256  fill data, valid with pmem_resp
- pmem_wdata  out  256  victim line data
- pmem_resp  in  1  memory completion pulse

Behaviour:
- Storage: per set a valid bit, dirty bit, tag and 256-bit data, all flops. Reads are combinational, so a hit completes with no array latency.
- FSM states: CHECK, WRITEBACK, FILL.
- Reset, applied at the clock edge where rst=1:
  - state goes to CHECK; all valid and dirty bits clear.
  - Outputs are decoded from state, so after reset mem_resp, pmem_read and pmem_write are 0. pmem_address and pmem_wdata are don't-care while their strobes are low.
  - A reset mid-WRITEBACK or mid-FILL abandons the transaction. No array update occurs.
- CHECK, no request: idle; all strobes 0.
- CHECK, request and hit (valid and tag match):
  - mem_resp=1 combinationally in the same cycle.
  - Read: mem_rdata = line word at offset[4:2].
  - Write: at the clock edge, merge only the enabled bytes into that word and set dirty.
  - Stay in CHECK. The requester drops its strobe after mem_resp; a strobe still high on the next cycle is a new request.
- CHECK, request and miss:
  - mem_resp=0.
  - Go to WRITEBACK if the victim is valid and dirty, else go to FILL.
- WRITEBACK:
  - pmem_write=1, pmem_address = {victim_tag, index, 5'b0}, pmem_wdata = victim line.
  - Hold until pmem_resp, then clear dirty and go to FILL.
- FILL:
  - pmem_read=1, pmem_address = {mem_address[31:5], 5'b0}.
  - On pmem_resp: write pmem_rdata to the line, set valid, clear dirty, load tag, go to CHECK.
  - The request then hits in CHECK one cycle later.
  - Miss latency = memory latency + 2 cycles (clean victim), plus writeback latency if dirty.
- mem_read and mem_write both high: treated as a write.
- Byte-enable 0000 write: hit response, data unchanged, dirty still set.
- Request signals may change only after mem_resp. The cache uses the live mem_address throughout a miss, so the address must stay stable.
- pmem_read and pmem_write are never high together.

Optional Feature:
- Macro: L1_CACHE_PERF_CNT_EN.
- Defined:
  - adds outputs perf_hits, perf_misses, perf_writebacks, each 32 bits.
  - Counters clear on rst and increment on CHECK-hit response, CHECK-to-miss transition, and WRITEBACK completion respectively.
  - Counters wrap at 2**32.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Cold read: rst, then read 0x0000_0040, pmem returns line with word1 = 0xDEAD_BEEF after 5 cycles.
  - One pmem_read to 0x0000_0040, then mem_resp with mem_rdata = 0x0000_0000 (word0).
  - Read 0x44 then hits with 0xDEAD_BEEF and no pmem activity.
- Byte write hit: after the fill above, write 0x44 with be=0010, data 0x0000_AB00.
  - mem_resp same cycle.
  - Read 0x44 returns 0xDEAD_ABEF.
- Dirty eviction (S_INDEX=3): after the dirty 0x40 line, read 0x0000_0140 (same index, new tag).
  - pmem_write first at 0x0000_0040 carrying the modified line.
  - Then pmem_read at 0x0000_0140, then mem_resp.
- Clean eviction: read 0x80, then read 0x180.
  - Only pmem_read transactions; pmem_write never asserts.
- Reset mid-fill: assert rst while pmem_read is high.
  - Next cycle pmem_read=0 and state is CHECK.
  - A repeat read of the same address misses again.
- Counters (macro defined): the sequence of scenarios 1-3 gives hits=3, misses=2, writebacks=1.
